goalpost_loader: RTL and testbench

GOALPOST_LOADER -- requirements
Module: goalpost_loader

---
 rtl/goalpost_loader.sv | 124 ++++++++++++
 tb/tb_goalpost_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goalpost_loader.sv
// goalpost_loader: unpacks 32-bit words of 16 two-bit palette codes from the
// processor bus and writes them, one pixel per cycle, into the left or right
// goalpost sprite RAM. A complete load is DEPTH pixels at addresses 0..DEPTH-1.
//
// Handshake: wr_data is taken on any rising edge where wr_valid=1 and
// wr_ready=1. wr_ready is high only in WAIT and only while no abort is pending,
// so a word offered in the same cycle as an abort is never consumed. wr_valid
// may be held or dropped freely. The block never stalls the processor outside
// WAIT; data offered then is simply not taken.
module goalpost_loader #(
   parameter int ADDR  = 10,
   parameter int DEPTH = 640
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            target,
   input  logic            abort,
   input  logic [31:0]     wr_data,
   input  logic            wr_valid,
   output logic            wr_ready,
   output logic            we_l,
   output logic            we_r,
   output logic [ADDR-1:0] addr_w,
   output logic [1:0]      pixel_out,
   output logic            busy,
   output logic            done,
   output logic [1:0]      o_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_target;
   logic [ADDR-1:0] r_cnt;
   logic [31:0]     r_data;
   logic [3:0]      r_k;

   logic            w_busy;
   logic            w_start;
   logic            w_abort;
   logic            w_xfer;
   logic            w_write;
   logic            w_last_pix;

   // Qualified control events: start only from IDLE/DONE, abort only while busy.
   always_comb begin
      w_busy     = (r_state == S_WAIT) || (r_state == S_WRITE);
      w_start    = start && !w_busy;
      w_abort    = abort && w_busy;
      w_xfer     = (r_state == S_WAIT) && wr_valid && !abort;
      w_write    = (r_state == S_WRITE) && !abort;
      w_last_pix = (r_cnt == ADDR'(DEPTH - 1));
   end

   // Next-state logic and all outputs, decoded from the registered state.
   always_comb begin
      w_next    = r_state;
      wr_ready  = 1'b0;
      we_l      = 1'b0;
      we_r      = 1'b0;
      pixel_out = 2'b00;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start) w_next = S_WAIT;
         end
         S_WAIT: begin
            wr_ready = !abort;
            if (abort)       w_next = S_IDLE;
            else if (w_xfer) w_next = S_WRITE;
         end
         S_WRITE: begin
            pixel_out = r_data[{r_k, 1'b0} +: 2];
            we_l      = w_write && !r_target;
            we_r      = w_write && r_target;
            // The last pixel of the bitmap ends the load even mid-word.
            if (abort)            w_next = S_IDLE;
            else if (w_last_pix)  w_next = S_DONE;
            else if (r_k == 4'hF) w_next = S_WAIT;
         end
         default: w_next = S_IDLE;
      endcase
      addr_w  = r_cnt;
      busy    = w_busy;
      done    = (r_state == S_DONE);
      o_state = r_state;
   end

   // State register plus target latch, pixel counter and word/pixel-index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_target <= 1'b0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_k      <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_target <= target;
            r_cnt    <= '0;
            r_k      <= '0;
         end
         if (w_abort) begin
            r_cnt <= '0;
         end
         if (w_xfer) begin
            r_data <= wr_data;
            r_k    <= '0;
         end
         if (w_write) begin
            r_cnt <= r_cnt + 1'b1;
            r_k   <= r_k + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_goalpost_loader.sv
// Directed bench for goalpost_loader: a cycle table for the control path and
// single-word unpacking, then hand sequences for full load, backpressure,
// aborts and mid-load reset. RAM writes are checked against an expected queue
// of {we_r, addr, pixel} entries.
module tb_goalpost_loader;

   localparam int ADDR  = 10;
   localparam int DEPTH = 640;
   localparam int W     = 1 + ADDR + 2;

   logic            clk;
   logic            reset;
   logic            start;
   logic            target;
   logic            abort;
   logic [31:0]     wr_data;
   logic            wr_valid;
   logic            wr_ready;
   logic            we_l;
   logic            we_r;
   logic [ADDR-1:0] addr_w;
   logic [1:0]      pixel_out;
   logic            busy;
   logic            done;
   logic [1:0]      o_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_en = 0;
   logic [W-1:0] exp_q[$];

   goalpost_loader #(.ADDR(ADDR), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .target(target), .abort(abort),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .we_l(we_l), .we_r(we_r), .addr_w(addr_w), .pixel_out(pixel_out),
      .busy(busy), .done(done), .o_state(o_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   // Scoreboard: every RAM write must match the head of the expected queue.
   task automatic mon_check();
      logic [W-1:0] got;
      logic [W-1:0] e;
      if (mon_en && (we_l || we_r)) begin
         total++;
         got = {we_r, addr_w, pixel_out};
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected got r=%0b addr=%0d pix=%0d need no write", we_r, addr_w, pixel_out);
         end else begin
            e = exp_q.pop_front();
            if (!(we_l ^ we_r) || got !== e)
               begin
                  bad++;
                  $display("FAIL wr_data got l=%0b r=%0b addr=%0d pix=%0d need r=%0b addr=%0d pix=%0d",
                           we_l, we_r, addr_w, pixel_out, e[W-1], e[W-2:2], e[1:0]);
               end
         end
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
      mon_check();
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
      total++;
      if (got !== need) begin
         bad++;
         $display("FAIL %s got=%0h need=%0h", name, got, need);
      end
   endtask

   function automatic void push_word(input logic side, input int base, input logic [31:0] d, input int n);
      for (int k = 0; k < n; k++)
         exp_q.push_back({side, ADDR'(base + k), d[2*k +: 2]});
   endfunction

   task automatic pulse_start(input logic tgt);
      start = 1'b1; target = tgt;
      at_neg(); to_next();
      start = 1'b0; target = 1'b0;
   endtask

   task automatic accept_word(input logic [31:0] d);
      bit acc;
      int n;
      wr_valid = 1'b1; wr_data = d; acc = 0; n = 0;
      while (!acc && n < 40) begin
         at_neg();
         acc = wr_ready;
         to_next();
         n++;
      end
      wr_valid = 1'b0; wr_data = '0;
      check("accept", {31'd0, acc}, 32'd1);
   endtask

   // Called in WAIT; holds wr_valid low for gap cycles, transfers d, runs its 16 writes.
   task automatic run_word(input logic [31:0] d, input int gap);
      wr_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         at_neg();
         check("bp_ready_nowrite", {29'd0, wr_ready, we_l, we_r}, 32'b100);
         to_next();
      end
      accept_word(d);
      for (int k = 0; k < 16; k++) begin
         at_neg(); to_next();
      end
   endtask

   typedef struct {
      logic        rst, st, tgt, ab, vld;
      logic [31:0] data;
      logic [16:0] exp_out; // {ready, we_l, we_r, busy, done, addr[9:0], pix[1:0]}
   } vec_t;

   function automatic vec_t mk(input logic rst, st, tgt, ab, vld, input logic [31:0] d,
                               input logic rdy, wl, wr, bz, dn,
                               input logic [9:0] a, input logic [1:0] p);
      vec_t v;
      v.rst = rst; v.st = st; v.tgt = tgt; v.ab = ab; v.vld = vld; v.data = d;
      v.exp_out = {rdy, wl, wr, bz, dn, a, p};
      return v;
   endfunction

   vec_t vecs[25];

   logic [31:0] wd[40];

   initial begin
      int acc_cyc, last_cyc, done_cyc, widx;
      bit got_done;
      logic [16:0] got;
      logic done_busy;

      // Reset
      reset = 1'b1; start = 1'b0; target = 1'b0; abort = 1'b0;
      wr_data = '0; wr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Cycle table: single word E4E4E4E4 to the left RAM, start/data ignored
      // during WRITE, abort+start in WAIT, abort in IDLE.
      vecs[0] = mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 10'd0, 2'd0);
      vecs[1] = mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 10'd0, 2'd0);
      vecs[2] = mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 10'd0, 2'd0);
      vecs[3] = mk(0, 0, 1, 0, 1, 32'hE4E4_E4E4, 1, 0, 0, 1, 0, 10'd0, 2'd0);
      for (int k = 0; k < 16; k++)
         vecs[4+k] = mk(0, (k == 5), 1, 0, (k >= 10), 32'hFFFF_FFFF,
                        0, 1, 0, 1, 0, 10'(k), 2'(k % 4));
      vecs[20] = mk(0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 0, 10'd16, 2'd0);
      vecs[21] = mk(0, 1, 0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 10'd16, 2'd0);
      vecs[22] = mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 10'd0, 2'd0);
      vecs[23] = mk(0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 10'd0, 2'd0);
      vecs[24] = mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 10'd0, 2'd0);

      for (int i = 0; i < 25; i++) begin
         reset = vecs[i].rst; start = vecs[i].st; target = vecs[i].tgt;
         abort = vecs[i].ab; wr_valid = vecs[i].vld; wr_data = vecs[i].data;
         at_neg();
         got = {wr_ready, we_l, we_r, busy, done, addr_w, pixel_out};
         total++;
         if (got !== vecs[i].exp_out) begin
            bad++;
            $display("FAIL vec%0d got rdy,wl,wr,busy,done,addr,pix=%b need %b", i, got, vecs[i].exp_out);
         end
         to_next();
      end
      reset = 1'b0; start = 1'b0; target = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = '0;

      // Full load to the right RAM, words streamed back to back.
      mon_en = 1;
      for (int w = 0; w < 40; w++) begin
         wd[w] = 32'h9C63_D2A5 ^ (32'(w) * 32'h0111_0101);
         push_word(1'b1, w * 16, wd[w], 16);
      end
      pulse_start(1'b1);
      widx = 0; got_done = 0; acc_cyc = -1; last_cyc = -1; done_cyc = -1; done_busy = 1'b1;
      for (int c = 0; c < 1500 && !got_done; c++) begin
         wr_valid = (widx < 40);
         wr_data  = wd[(widx < 40) ? widx : 39];
         at_neg();
         if (wr_ready && wr_valid) begin
            if (widx == 0) acc_cyc = cyc;
            widx++;
         end
         if (we_r && addr_w == 10'd639) last_cyc = cyc;
         if (done) begin
            got_done = 1; done_cyc = cyc; done_busy = busy;
         end
         to_next();
      end
      wr_valid = 1'b0; wr_data = '0;
      check("full_done_seen", {31'd0, got_done}, 32'd1);
      check("full_cycles", 32'(done_cyc - acc_cyc), 32'd680);
      check("full_done_after_last", 32'(done_cyc - last_cyc), 32'd1);
      check("full_busy_in_done", {31'd0, done_busy}, 32'd0);
      check("full_queue_empty", 32'(exp_q.size()), 32'd0);

      // Start from DONE clears done and re-enters WAIT at address 0.
      pulse_start(1'b0);
      at_neg();
      check("restart_from_done", {28'd0, busy, done, wr_ready, (addr_w == 10'd0)}, 32'b1011);
      to_next();
      abort = 1'b1; at_neg(); to_next(); abort = 1'b0;

      // Backpressure between words, then abort after three words.
      wd[0] = 32'h1B2D_3C4E; wd[1] = 32'hA5A5_5A5A; wd[2] = 32'h0F0F_F0F0;
      for (int w = 0; w < 3; w++) push_word(1'b0, w * 16, wd[w], 16);
      pulse_start(1'b0);
      run_word(wd[0], 0);
      run_word(wd[1], 5);
      run_word(wd[2], 5);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
      abort = 1'b1;
      at_neg(); to_next();
      abort = 1'b0;
      for (int c = 0; c < 20; c++) begin
         at_neg();
         if (c == 0 || c == 19)
            check("after_abort_idle", {28'd0, busy, done, we_l, we_r}, 32'd0);
         to_next();
      end

      // Abort in the middle of a word: four writes, none in the abort cycle.
      wd[3] = 32'h7777_1234;
      push_word(1'b0, 0, wd[3], 4);
      pulse_start(1'b0);
      accept_word(wd[3]);
      for (int k = 0; k < 4; k++) begin
         at_neg(); to_next();
      end
      abort = 1'b1;
      at_neg();
      check("abort_drops_we", {30'd0, we_l, we_r}, 32'd0);
      to_next();
      abort = 1'b0;
      repeat (10) begin at_neg(); to_next(); end
      check("midabort_state", {30'd0, busy, done}, 32'd0);
      check("midabort_queue", 32'(exp_q.size()), 32'd0);

      // Restart begins at address 0.
      wd[4] = 32'hC3C3_9696;
      push_word(1'b0, 0, wd[4], 16);
      pulse_start(1'b0);
      run_word(wd[4], 0);
      check("restart_queue", 32'(exp_q.size()), 32'd0);
      abort = 1'b1; at_neg(); to_next(); abort = 1'b0;

      // Reset asserted while address 100 is being written.
      for (int w = 0; w < 7; w++) begin
         wd[w] = 32'h3141_5926 + 32'(w) * 32'h2718_2818;
         push_word(1'b0, w * 16, wd[w], (w < 6) ? 16 : 5);
      end
      pulse_start(1'b0);
      for (int w = 0; w < 6; w++) run_word(wd[w], 0);
      accept_word(wd[6]);
      for (int k = 0; k < 4; k++) begin
         at_neg(); to_next();
      end
      reset = 1'b1;
      at_neg();
      check("rst_at_addr", {21'd0, we_l, addr_w}, {21'd0, 1'b1, 10'd100});
      to_next();
      reset = 1'b0;
      at_neg();
      check("rst_outputs_zero",
            {16'd0, wr_ready, we_l, we_r, busy, done, addr_w, pixel_out}, 32'd0);
      to_next();
      repeat (20) begin at_neg(); to_next(); end
      check("rst_queue", 32'(exp_q.size()), 32'd0);
      check("rst_idle", {30'd0, busy, done}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
